// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: multiply-unit FSM
// encodings, the "source unused" Tuse marker and default multiply-unit latencies.
package pipe_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Tuse value meaning the D instruction never reads that source register
    localparam logic [1:0] TUSE_UNUSED = 2'd3;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Multiply-unit occupancy timer: IDLE/BUSY FSM with a down-counter loaded at
// operation start; o_busy is high exactly while the operation is in flight.
module md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    input  logic i_req,
    output logic o_busy
);

    localparam int CW = $clog2(DIV_CYC + 1);

    md_state_t       r_state;
    md_state_t       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A start is only honoured from IDLE and never for a flushed instruction;
    // a flush arriving mid-operation lets the operation run to completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (i_start && !i_req) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = i_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
                end
            end
            MD_BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = MD_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: register-dependency and multiply-unit hazards.
// Optional stall counter output enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [1:0]  D_TuseRs,
    input  logic [1:0]  D_TuseRt,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        D_isMD,
    input  logic        E_start,
    input  logic        E_isDiv,
    input  logic        Req,
    output logic        F_PC_WE,
    output logic        D_WE,
    output logic        E_clr,
    output logic        MD_Busy,
`ifdef PIPE_CTRL_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        Stall
);

    logic w_rs_stall;
    logic w_rt_stall;
    logic w_data_stall;
    logic w_md_stall;

    // Register 0 is never a real dependency; a Tnew larger than Tuse means the
    // producer cannot forward in time.
    assign w_rs_stall = (D_A1 != 5'd0) && (D_TuseRs != TUSE_UNUSED) &&
                        (((D_A1 == E_A3) && (E_Tnew > D_TuseRs)) ||
                         ((D_A1 == M_A3) && (M_Tnew > D_TuseRs)));
    assign w_rt_stall = (D_A2 != 5'd0) && (D_TuseRt != TUSE_UNUSED) &&
                        (((D_A2 == E_A3) && (E_Tnew > D_TuseRt)) ||
                         ((D_A2 == M_A3) && (M_Tnew > D_TuseRt)));

    assign w_data_stall = w_rs_stall || w_rt_stall;
    assign w_md_stall   = D_isMD && (E_start || MD_Busy);

    assign Stall   = (w_data_stall || w_md_stall) && !Req;
    assign F_PC_WE = !Stall;
    assign D_WE    = !Stall;
    assign E_clr   = Stall;

    md_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (E_start),
        .i_is_div (E_isDiv),
        .i_req    (Req),
        .o_busy   (MD_Busy)
    );

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (Stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs into a
// queue; a negedge monitor pops and compares each cycle.
module tb_pipe_ctrl;

    logic        clk = 1'b1;
    logic        reset;
    logic [4:0]  D_A1, D_A2, E_A3, M_A3;
    logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
    logic        D_isMD, E_start, E_isDiv, Req;
    logic        F_PC_WE, D_WE, E_clr, MD_Busy, Stall;
`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .D_A1     (D_A1),
        .D_A2     (D_A2),
        .D_TuseRs (D_TuseRs),
        .D_TuseRt (D_TuseRt),
        .E_A3     (E_A3),
        .M_A3     (M_A3),
        .E_Tnew   (E_Tnew),
        .M_Tnew   (M_Tnew),
        .D_isMD   (D_isMD),
        .E_start  (E_start),
        .E_isDiv  (E_isDiv),
        .Req      (Req),
        .F_PC_WE  (F_PC_WE),
        .D_WE     (D_WE),
        .E_clr    (E_clr),
        .MD_Busy  (MD_Busy),
`ifdef PIPE_CTRL_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .Stall    (Stall)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        bit          chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic clr();
        D_A1 = 0; D_A2 = 0; E_A3 = 0; M_A3 = 0;
        D_TuseRs = 2'd3; D_TuseRt = 2'd3; E_Tnew = 0; M_Tnew = 0;
        D_isMD = 0; E_start = 0; E_isDiv = 0; Req = 0;
    endtask

    // Inputs are already applied; queue the expectation and advance one cycle.
    task automatic vecc(input string nm, input logic es, input logic eb,
                        input bit cc, input logic [31:0] ec);
        exp_t e;
        e.name = nm; e.stall = es; e.busy = eb; e.chk_cnt = cc; e.cnt = ec;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic vec(input string nm, input logic es, input logic eb);
        vecc(nm, es, eb, 1'b0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                bad = (Stall !== e.stall) || (F_PC_WE !== !e.stall) ||
                      (D_WE !== !e.stall) || (E_clr !== e.stall) ||
                      (MD_Busy !== e.busy);
`ifdef PIPE_CTRL_STALL_CNT_EN
                if (e.chk_cnt && (stall_cnt !== e.cnt)) bad = 1'b1;
`endif
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s: got Stall=%b F_PC_WE=%b D_WE=%b E_clr=%b MD_Busy=%b, want Stall=%b MD_Busy=%b",
                             e.name, Stall, F_PC_WE, D_WE, E_clr, MD_Busy, e.stall, e.busy);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin : stim
        clr();
        reset = 1'b0;
        @(posedge clk); #1;

        vec("rst_idle", 0, 0);
        D_A1 = 5; D_TuseRs = 0; E_A3 = 5; E_Tnew = 1;
        vec("rst_comb_stall", 1, 0);
        reset = 1'b1;
        #1;
        if ((Stall !== 1'b1) || (D_WE !== 1'b0) || (F_PC_WE !== 1'b0) || (E_clr !== 1'b1)) begin
            miscompares++;
            $display("FAIL direct_e_hazard: got Stall=%b D_WE=%b F_PC_WE=%b E_clr=%b, want 1 0 0 1",
                     Stall, D_WE, F_PC_WE, E_clr);
        end
        vec("e_hazard_rs", 1, 0);
        D_A1 = 0;
        #1;
        if (Stall !== 1'b0) begin
            miscompares++;
            $display("FAIL direct_a1_zero: got Stall=%b, want 0", Stall);
        end
        vec("a1_zero", 0, 0);
        clr(); D_A2 = 7; D_TuseRt = 1; M_A3 = 7; M_Tnew = 2;
        vec("m_hazard_rt", 1, 0);
        M_Tnew = 1;
        vec("m_tnew_eq_tuse", 0, 0);
        clr(); D_A1 = 9; D_TuseRs = 3; E_A3 = 9; E_Tnew = 3;
        vec("tuse_unused", 0, 0);

        // mult: busy for 5 cycles after the start edge
        clr(); E_start = 1;
        vec("mult_start", 0, 0);
        if (MD_Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_mult_busy: got MD_Busy=%b, want 1", MD_Busy);
        end
        for (int i = 1; i <= 5; i++) begin
            clr(); D_isMD = (i == 3);
            vec($sformatf("mult_busy%0d", i), (i == 3), 1);
        end
        if (MD_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL direct_mult_done: got MD_Busy=%b, want 0", MD_Busy);
        end
        clr();
        vec("mult_done", 0, 0);

        // MD instruction in D while E starts a div; second start at t+4 ignored
        clr(); D_isMD = 1; E_start = 1; E_isDiv = 1;
        vec("md_start_stall", 1, 0);
        for (int i = 1; i <= 10; i++) begin
            clr(); E_start = (i == 4);
            vec($sformatf("div_busy%0d", i), 0, 1);
        end
        clr();
        vec("div_done", 0, 0);

        // flush request overrides stalls but not the running operation
        clr(); D_A1 = 5; D_TuseRs = 0; E_A3 = 5; E_Tnew = 1; Req = 1;
        vec("req_data", 0, 0);
        clr(); E_start = 1;
        vec("mult_start2", 0, 0);
        clr(); D_isMD = 1; Req = 1;
        #1;
        if ((Stall !== 1'b0) || (D_WE !== 1'b1) || (MD_Busy !== 1'b1)) begin
            miscompares++;
            $display("FAIL direct_req_busy: got Stall=%b D_WE=%b MD_Busy=%b, want 0 1 1",
                     Stall, D_WE, MD_Busy);
        end
        for (int i = 1; i <= 5; i++) begin
            clr(); D_isMD = 1; Req = (i <= 2);
            vec($sformatf("req_busy%0d", i), (i > 2), 1);
        end
        clr();
        vec("req_done", 0, 0);

        clr(); E_start = 1; Req = 1;
        vec("start_req", 0, 0);
        clr();
        vec("start_req_idle1", 0, 0);
        vec("start_req_idle2", 0, 0);

        // reset in the third busy cycle returns to idle on that edge
        clr(); E_start = 1;
        vec("start3", 0, 0);
        clr();
        vec("b1", 0, 1);
        vec("b2", 0, 1);
        reset = 1'b0;
        vec("b3_rst", 0, 1);
        reset = 1'b1;
        vec("after_rst", 0, 0);

`ifdef PIPE_CTRL_STALL_CNT_EN
        clr(); reset = 1'b0;
        vec("cnt_rst", 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clr(); D_A1 = 3; D_TuseRs = 0; M_A3 = 3; M_Tnew = 2;
            vecc($sformatf("cnt_stall%0d", i), 1, 0, 1'b1, 32'(i));
        end
        clr();
        vecc("cnt_seven", 0, 0, 1'b1, 32'd7);
        vecc("cnt_hold", 0, 0, 1'b1, 32'd7);
`endif

        @(posedge clk); #1;
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL vector_count: got %0d vectors, want at least 12", vectors);
        end
        if (miscompares != 0)
            $display("FAIL == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        else
            $display("PASS == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
